uart_rx: RTL and testbench

UART receiver: the serial-to-parallel counterpart of the UART transmitter in the UART peripheral. It synchronises the `rxd` line and detects start bits using a 16x oversampling tick. It assembles 5–8 data bits LSB first, checks parity and stop bits, and detects line breaks. Each received character and its error flags are stored in a receive buffer, which the register interface reads.

---
 rtl/uart_rx.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with parity/framing/break detection and a receive buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry circular FIFO; otherwise a single holding register.
module uart_rx #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            os_edge_i,
  input  logic                            rxd,
  input  logic [1:0]                      word_len_i,
  input  logic                            par_en_i,
  input  logic [1:0]                      par_sel_i,
  input  logic                            rd_i,
  input  logic                            fifo_clr_i,
  input  logic                            overrun_clr_i,
  output logic                            rx_valid_o,
  output logic [7:0]                      rx_data_o,
  output logic                            rx_pe_o,
  output logic                            rx_fe_o,
  output logic                            rx_bi_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count_o,
  output logic                            overrun_o,
  output logic                            busy_o
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_WAIT
  } state_t;

  logic   sync1_q, sync2_q, rxs;
  state_t state_q, state_d;
  logic [3:0] os_cnt_q, os_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       pe_q, pe_d;
  logic       par_bit_q, par_bit_d;
  logic       overrun_q, overrun_d;

  logic [2:0]  last_idx;
  logic [7:0]  data_mask, data_masked;
  logic        tick_mid, tick_end, par_exp;
  logic        push, push_ok, push_bi, push_fe;
  logic [7:0]  push_data;
  logic [10:0] push_entry;
  logic [10:0] head;
  logic        head_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end
  assign rxs = sync2_q;

  assign last_idx = {1'b0, word_len_i} + 3'd4;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mask
      assign data_mask[gi] = (3'(gi) <= last_idx);
    end
  endgenerate

  assign data_masked = shift_q & data_mask;
  assign tick_mid    = os_edge_i && (os_cnt_q == 4'd7);
  assign tick_end    = os_edge_i && (os_cnt_q == 4'd15);

  always_comb begin
    par_exp = 1'b0;
    case (par_sel_i)
      2'b00:   par_exp = ~^data_masked;
      2'b01:   par_exp = ^data_masked;
      2'b10:   par_exp = 1'b1;
      default: par_exp = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      os_cnt_q  <= 4'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      pe_q      <= 1'b0;
      par_bit_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      pe_q      <= pe_d;
      par_bit_q <= par_bit_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_edge_i ? os_cnt_q + 4'd1 : os_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pe_d      = pe_q;
    par_bit_d = par_bit_q;
    push      = 1'b0;
    push_bi   = 1'b0;
    push_fe   = 1'b0;
    push_data = data_masked;
    case (state_q)
      ST_IDLE: begin
        os_cnt_d = 4'd0;
        if (!rxs) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick_mid) begin
          os_cnt_d = 4'd0;
          if (!rxs) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
            shift_d   = 8'd0;
            pe_d      = 1'b0;
            par_bit_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tick_end) begin
          shift_d[bit_idx_q] = rxs;
          bit_idx_d          = bit_idx_q + 3'd1;
          // bit_idx wraps if word_len shrinks mid-character, so the FSM still exits
          if (bit_idx_q == last_idx) begin
            os_cnt_d = 4'd0;
            state_d  = par_en_i ? ST_PAR : ST_STOP;
          end
        end
      end
      ST_PAR: begin
        if (tick_end) begin
          par_bit_d = rxs;
          pe_d      = (rxs != par_exp);
          os_cnt_d  = 4'd0;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick_end) begin
          push      = 1'b1;
          push_bi   = (data_masked == 8'd0) && !par_bit_q && !rxs;
          push_fe   = !rxs;
          push_data = push_bi ? 8'd0 : data_masked;
          os_cnt_d  = 4'd0;
          state_d   = rxs ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        os_cnt_d = 4'd0;
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        os_cnt_d = 4'd0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  assign push_entry = {push_bi, push_fe, pe_q, push_data};

  always_comb begin
    overrun_d = overrun_q;
    if (fifo_clr_i) begin
      overrun_d = 1'b0;
    end else if (push && !push_ok) begin
      overrun_d = 1'b1;
    end else if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [10:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, do_pop, do_push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = rd_i && !empty;
  assign push_ok = !full || do_pop;
  assign do_push = push && push_ok && !fifo_clr_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_entry;
    end
  end

  // Head is read combinationally so it is valid in the same cycle as rx_valid_o
  assign head       = mem[rd_ptr_q];
  assign head_valid = !empty;
  assign rx_count_o = count_q;
`else
  logic        hold_valid_q, hold_valid_d;
  logic [10:0] hold_q, hold_d;

  assign push_ok = !hold_valid_q || rd_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid_q <= 1'b0;
      hold_q       <= 11'd0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
    end
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    if (fifo_clr_i) begin
      hold_valid_d = 1'b0;
    end else begin
      if (rd_i) begin
        hold_valid_d = 1'b0;
      end
      if (push && push_ok) begin
        hold_valid_d = 1'b1;
        hold_d       = push_entry;
      end
    end
  end

  assign head       = hold_q;
  assign head_valid = hold_valid_q;
  assign rx_count_o = CNT_W'(hold_valid_q);
`endif

  assign rx_valid_o = head_valid;
  assign rx_data_o  = head_valid ? head[7:0] : 8'd0;
  assign rx_pe_o    = head_valid & head[8];
  assign rx_fe_o    = head_valid & head[9];
  assign rx_bi_o    = head_valid & head[10];
  assign overrun_o  = overrun_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of characters with hand-derived expected flags, scoreboarded
// against the buffer head, plus glitch, break, overrun, flush and push-with-pop sequences.
module tb_uart_rx;
  localparam int FIFO_DEPTH = 16;
`ifdef UART_RX_FIFO_EN
  localparam int D = FIFO_DEPTH;
`else
  localparam int D = 1;
`endif
  localparam int BIT_CLKS = 64;  // 16 ticks per bit, one tick every 4 clocks
  localparam int NV = 12;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       os_edge_i = 1'b0;
  logic       rxd = 1'b1;
  logic [1:0] word_len_i = 2'b11;
  logic       par_en_i = 1'b0;
  logic [1:0] par_sel_i = 2'b00;
  logic       rd_i = 1'b0;
  logic       fifo_clr_i = 1'b0;
  logic       overrun_clr_i = 1'b0;
  logic       rx_valid_o;
  logic [7:0] rx_data_o;
  logic       rx_pe_o, rx_fe_o, rx_bi_o;
  logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count_o;
  logic       overrun_o, busy_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] wl;
    logic       pen;
    logic [1:0] psel;
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
    logic       exp_bi;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       bi;
  } exp_t;

  vec_t vecs[NV];
  exp_t sb[$];

  uart_rx #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .os_edge_i(os_edge_i),
    .rxd(rxd),
    .word_len_i(word_len_i),
    .par_en_i(par_en_i),
    .par_sel_i(par_sel_i),
    .rd_i(rd_i),
    .fifo_clr_i(fifo_clr_i),
    .overrun_clr_i(overrun_clr_i),
    .rx_valid_o(rx_valid_o),
    .rx_data_o(rx_data_o),
    .rx_pe_o(rx_pe_o),
    .rx_fe_o(rx_fe_o),
    .rx_bi_o(rx_bi_o),
    .rx_count_o(rx_count_o),
    .overrun_o(overrun_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin : tick_gen
    logic [1:0] div;
    div = 2'd0;
    forever begin
      @(posedge clk_i);
      #1;
      div = div + 2'd1;
      os_edge_i = (div == 2'd0);
    end
  end

  initial begin : watchdog
    #(95000 * 10);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_char(input logic [7:0] d, input int nbits, input logic pen,
                           input logic pbit, input logic stop);
    rxd = 1'b0;
    hold(BIT_CLKS);
    for (int i = 0; i < nbits; i++) begin
      rxd = d[i];
      hold(BIT_CLKS);
    end
    if (pen) begin
      rxd = pbit;
      hold(BIT_CLKS);
    end
    rxd = stop;
    hold(BIT_CLKS);
    rxd = 1'b1;
    hold(16);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!rx_valid_o && n < 2000) begin
      hold(1);
      n++;
    end
    check(name, 32'(rx_valid_o), 1);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_sb actual=valid:%0b required=no_entry_expected", tag, rx_valid_o);
      return;
    end
    e = sb.pop_front();
    check({tag, "_valid"}, 32'(rx_valid_o), 1);
    check({tag, "_data"}, 32'(rx_data_o), 32'(e.data));
    check({tag, "_pe"}, 32'(rx_pe_o), 32'(e.pe));
    check({tag, "_fe"}, 32'(rx_fe_o), 32'(e.fe));
    check({tag, "_bi"}, 32'(rx_bi_o), 32'(e.bi));
    $display("pop %s data=0x%02h pe=%0b fe=%0b bi=%0b", tag, rx_data_o, rx_pe_o, rx_fe_o, rx_bi_o);
    rd_i = 1'b1;
    hold(1);
    rd_i = 1'b0;
  endtask

  initial begin : main
    int n;
    //            wl    pen   psel  data   pbit  stop  exp    pe    fe    bi
    vecs[0]  = '{2'd3, 1'b0, 2'd0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'd2, 1'b1, 2'd0, 8'h41, 1'b0, 1'b1, 8'h41, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{2'd2, 1'b1, 2'd0, 8'h41, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{2'd3, 1'b1, 2'd1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{2'd0, 1'b0, 2'd0, 8'h15, 1'b0, 1'b1, 8'h15, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{2'd1, 1'b1, 2'd2, 8'h2A, 1'b0, 1'b1, 8'h2A, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{2'd3, 1'b0, 2'd0, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{2'd1, 1'b1, 2'd3, 8'h3F, 1'b0, 1'b1, 8'h3F, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{2'd3, 1'b1, 2'd1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{2'd3, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{2'd0, 1'b1, 2'd0, 8'h13, 1'b0, 1'b1, 8'h13, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{2'd3, 1'b0, 2'd0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};

    // Reset state
    rst_i = 1'b1;
    hold(5);
    check("rst_valid", 32'(rx_valid_o), 0);
    check("rst_data", 32'(rx_data_o), 0);
    check("rst_flags", 32'({rx_pe_o, rx_fe_o, rx_bi_o}), 0);
    check("rst_count", 32'(rx_count_o), 0);
    check("rst_overrun", 32'(overrun_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    rst_i = 1'b0;
    hold(3);
    check("post_rst_busy", 32'(busy_o), 0);

    // A read of an empty buffer is ignored
    rd_i = 1'b1;
    hold(1);
    rd_i = 1'b0;
    hold(1);
    check("rd_empty_count", 32'(rx_count_o), 0);
    check("rd_empty_valid", 32'(rx_valid_o), 0);

    for (int v = 0; v < NV; v++) begin
      word_len_i = vecs[v].wl;
      par_en_i   = vecs[v].pen;
      par_sel_i  = vecs[v].psel;
      sb.push_back('{vecs[v].exp_data, vecs[v].exp_pe, vecs[v].exp_fe, vecs[v].exp_bi});
      send_char(vecs[v].data, int'(vecs[v].wl) + 5, vecs[v].pen, vecs[v].pbit, vecs[v].stop);
      wait_valid($sformatf("vec%0d_arrive", v));
      check($sformatf("vec%0d_count", v), 32'(rx_count_o), 1);
      pop_check($sformatf("vec%0d", v));
      check($sformatf("vec%0d_popped", v), 32'(rx_valid_o), 0);
    end

    // Short low glitch: START is entered 3 cycles after the fall, then abandoned
    word_len_i = 2'd3;
    par_en_i   = 1'b0;
    par_sel_i  = 2'd0;
    rxd = 1'b0;
    hold(2);
    check("glitch_busy_early", 32'(busy_o), 0);
    hold(1);
    check("glitch_busy_start", 32'(busy_o), 1);
    hold(13);
    rxd = 1'b1;
    n = 0;
    while (busy_o && n < 200) begin
      hold(1);
      n++;
    end
    check("glitch_back_idle", 32'(busy_o), 0);
    check("glitch_no_push", 32'(rx_count_o), 0);
    $display("glitch busy_cleared_after=%0d", n);

    // Line held low for three 8N1 character times yields exactly one break entry
    sb.push_back('{8'h00, 1'b0, 1'b1, 1'b1});
    rxd = 1'b0;
    hold(30 * BIT_CLKS);
    check("brk_wait_busy", 32'(busy_o), 1);
    check("brk_one_entry", 32'(rx_count_o), 1);
    rxd = 1'b1;
    hold(8);
    check("brk_idle", 32'(busy_o), 0);
    check("brk_still_one", 32'(rx_count_o), 1);
    pop_check("brk");

    // Overfill: D accepted, one lost, order preserved
    for (int i = 0; i <= D; i++) begin
      if (i < D) sb.push_back('{8'h30 + 8'(i), 1'b0, 1'b0, 1'b0});
      send_char(8'h30 + 8'(i), 8, 1'b0, 1'b0, 1'b1);
    end
    check("ovf_count", 32'(rx_count_o), D);
    check("ovf_overrun", 32'(overrun_o), 1);
    for (int i = 0; i < D; i++) pop_check($sformatf("ovf_rd%0d", i));
    check("ovf_drained", 32'(rx_valid_o), 0);
    check("ovf_sticky", 32'(overrun_o), 1);
    overrun_clr_i = 1'b1;
    hold(1);
    overrun_clr_i = 1'b0;
    check("ovf_clr", 32'(overrun_o), 0);

    // Overfill again, then flush
    for (int i = 0; i <= D; i++) send_char(8'h50 + 8'(i), 8, 1'b0, 1'b0, 1'b1);
    check("flush_pre_count", 32'(rx_count_o), D);
    check("flush_pre_overrun", 32'(overrun_o), 1);
    fifo_clr_i = 1'b1;
    hold(1);
    fifo_clr_i = 1'b0;
    check("flush_count", 32'(rx_count_o), 0);
    check("flush_overrun", 32'(overrun_o), 0);
    check("flush_valid", 32'(rx_valid_o), 0);

    // Full buffer with a pop in the same cycle as the push
    for (int i = 0; i < D; i++) begin
      sb.push_back('{8'h70 + 8'(i), 1'b0, 1'b0, 1'b0});
      send_char(8'h70 + 8'(i), 8, 1'b0, 1'b0, 1'b1);
    end
    check("simul_pre_count", 32'(rx_count_o), D);
    check("simul_pre_overrun", 32'(overrun_o), 0);
    sb.push_back('{8'h7F, 1'b0, 1'b0, 1'b0});
    fork
      send_char(8'h7F, 8, 1'b0, 1'b0, 1'b1);
      begin : watcher
        int t;
        exp_t e;
        t = 0;
        // START entry is 3 cycles after the fall; stop sample is tick 8 + 16*9 after it
        repeat (3) @(posedge clk_i);
        while (t < 152) begin
          @(negedge clk_i);
          if (os_edge_i) t++;
        end
        e = sb.pop_front();
        check("simul_head", 32'(rx_data_o), 32'(e.data));
        rd_i = 1'b1;
        @(posedge clk_i);
        #1;
        rd_i = 1'b0;
        check("simul_count", 32'(rx_count_o), D);
        check("simul_overrun", 32'(overrun_o), 0);
      end
    join
    for (int i = 0; i < D; i++) pop_check($sformatf("simul_rd%0d", i));
    check("simul_drained", 32'(rx_valid_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
